// File: rtl/uart_rx.sv
// 8-O-1 UART receiver with 2-flop synchroniser, parity/framing/overrun status and valid/read handshake.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 majority of three samples around bit centre.
module uart_rx #(
  parameter int CLOCK_FREQ     = 12_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       read_enable,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] BIT_TC = CW'(CLOCKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] START_TC = CW'(CLOCKS_PER_BIT / 2);
`else
  localparam logic [CW-1:0] START_TC = CW'(CLOCKS_PER_BIT / 2 - 1);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_pos_q, bit_pos_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [7:0]    data_q, data_d;
  logic          data_valid_q, data_valid_d;
  logic          parity_error_q, parity_error_d;
  logic          frame_error_q, frame_error_d;
  logic          overrun_q, overrun_d;
  logic          rx_meta_q, rx_s_q;
  logic          sample;

`ifdef UART_RX_MAJORITY_EN
  // The decision count is one past the centre sample, so the window is (centre-1, centre, centre+1).
  logic [1:0] hist_q;
  always_ff @(posedge clock) begin
    if (!reset) hist_q <= 2'b11;
    else        hist_q <= {hist_q[0], rx_s_q};
  end
  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
  assign sample = rx_s_q;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      bit_pos_q      <= '0;
      shift_q        <= '0;
      par_q          <= 1'b0;
      data_q         <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      overrun_q      <= 1'b0;
      rx_meta_q      <= 1'b1;
      rx_s_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_pos_q      <= bit_pos_d;
      shift_q        <= shift_d;
      par_q          <= par_d;
      data_q         <= data_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      frame_error_q  <= frame_error_d;
      overrun_q      <= overrun_d;
      rx_meta_q      <= rx;
      rx_s_q         <= rx_meta_q;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + CW'(1);
    bit_pos_d      = bit_pos_q;
    shift_d        = shift_q;
    par_d          = par_q;
    data_d         = data_q;
    data_valid_d   = data_valid_q;
    parity_error_d = parity_error_q;
    frame_error_d  = frame_error_q;
    overrun_d      = overrun_q;

    if (read_enable && data_valid_q) begin
      data_valid_d = 1'b0;
      overrun_d    = 1'b0;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == START_TC) begin
          cnt_d     = '0;
          bit_pos_d = '0;
          state_d   = sample ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_TC) begin
          cnt_d              = '0;
          shift_d[bit_pos_q] = sample;
          if (bit_pos_q == 3'd7) state_d = PARITY;
          else                   bit_pos_d = bit_pos_q + 3'd1;
        end
      end
      PARITY: begin
        if (cnt_q == BIT_TC) begin
          cnt_d   = '0;
          par_d   = sample;
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_TC) begin
          cnt_d          = '0;
          data_d         = shift_q;
          data_valid_d   = 1'b1;
          parity_error_d = ~(^{shift_q, par_q});
          frame_error_d  = ~sample;
          // A read landing on the commit cycle consumes the old byte, so no overrun.
          if (data_valid_q && !read_enable) overrun_d = 1'b1;
          state_d        = sample ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign data         = data_q;
  assign data_valid   = data_valid_q;
  assign parity_error = parity_error_q;
  assign frame_error  = frame_error_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, hand-written corner sequences, randomized frames vs. a frame-level model.
module tb_uart_rx;

  localparam int CPB = 12_000_000 / 115_200;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Edge index (counted from the rx falling edge drive) on which the stop bit is committed.
  localparam int COMMIT_IDX = 2 + CPB / 2 + 10 * CPB + MAJ;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       read_enable;
  logic       parity_error;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  uart_rx dut (
    .clock       (clock),
    .reset       (reset),
    .rx          (rx),
    .data        (data),
    .data_valid  (data_valid),
    .read_enable (read_enable),
    .parity_error(parity_error),
    .frame_error (frame_error),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic       rd;
    logic [7:0] e_data;
    logic       e_pe;
    logic       e_fe;
    logic       e_ov;
  } vec_t;

  vec_t vecs[7];

  // Frame-level model state
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_pe, m_fe, m_ov;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  // Drives one 11-bit frame; read_enable is raised only on loop index re_idx (-1 for none).
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int re_idx);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < 11 * CPB; i++) begin
      rx          = f[i / CPB];
      read_enable = (i == re_idx);
      tick();
    end
    read_enable = 1'b0;
    rx          = 1'b1;
    repeat (CPB) tick();
  endtask

  task automatic read_pulse();
    read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
  endtask

  task automatic model_commit(input logic [7:0] d, input logic p, input logic s);
    if (m_valid) m_ov = 1'b1;
    m_valid = 1'b1;
    m_data  = d;
    m_pe    = (($countones(d) + int'(p)) % 2) == 0;
    m_fe    = !s;
  endtask

  initial begin
    logic [7:0] rd8;
    logic       rp, rs;

    //            d      p     s     rd    e_data e_pe  e_fe  e_ov
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0};

    reset = 1'b0;
    rx = 1'b1;
    read_enable = 1'b0;
    repeat (5) tick();
    chk8("rst_data", data, 8'h00);
    chk1("rst_dv", data_valid, 1'b0);
    chk1("rst_pe", parity_error, 1'b0);
    chk1("rst_fe", frame_error, 1'b0);
    chk1("rst_ov", overrun, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    reset = 1'b1;
    repeat (CPB) tick();

    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].d, vecs[v].p, vecs[v].s, -1);
      chk8("vec_data", data, vecs[v].e_data);
      chk1("vec_dv", data_valid, 1'b1);
      chk1("vec_pe", parity_error, vecs[v].e_pe);
      chk1("vec_fe", frame_error, vecs[v].e_fe);
      chk1("vec_ov", overrun, vecs[v].e_ov);
      if (vecs[v].rd) begin
        read_pulse();
        chk1("vec_rd_dv", data_valid, 1'b0);
        chk1("vec_rd_ov", overrun, 1'b0);
      end
    end

    // Start-bit glitch of 20 clocks must be rejected
    for (int i = 0; i < 60; i++) begin
      rx = (i < 20) ? 1'b0 : 1'b1;
      tick();
      if (i == 10) chk1("glitch_busy_mid", busy, 1'b1);
    end
    chk1("glitch_busy_end", busy, 1'b0);
    chk1("glitch_dv", data_valid, 1'b0);
    repeat (CPB) tick();

    // Break: stop bit 0 and line held low for 3 bit times
    begin
      logic [10:0] f;
      f = {1'b0, 1'b1, 8'h00, 1'b0};
      for (int i = 0; i < 11 * CPB; i++) begin
        rx = f[i / CPB];
        tick();
      end
    end
    rx = 1'b0;
    repeat (CPB) tick();
    chk1("brk_dv", data_valid, 1'b1);
    chk1("brk_fe", frame_error, 1'b1);
    chk1("brk_pe", parity_error, 1'b0);
    chk1("brk_busy_hold", busy, 1'b1);
    read_pulse();
    chk1("brk_rd_dv", data_valid, 1'b0);
    repeat (2 * CPB - 1) tick();
    chk1("brk_no_refire", data_valid, 1'b0);
    chk1("brk_busy_late", busy, 1'b1);
    rx = 1'b1;
    repeat (10) tick();
    chk1("brk_busy_release", busy, 1'b0);
    chk1("brk_dv_release", data_valid, 1'b0);
    repeat (CPB) tick();

    // Randomized frames against the frame-level model
    m_valid = 1'b0; m_ov = 1'b0; m_data = 8'h00; m_pe = 1'b0; m_fe = 1'b0;
    for (int n = 0; n < 12; n++) begin
      rd8 = 8'($urandom);
      rp  = 1'($urandom);
      rs  = ($urandom_range(3) != 0);
      send_frame(rd8, rp, rs, -1);
      model_commit(rd8, rp, rs);
      chk8("rnd_data", data, m_data);
      chk1("rnd_dv", data_valid, m_valid);
      chk1("rnd_pe", parity_error, m_pe);
      chk1("rnd_fe", frame_error, m_fe);
      chk1("rnd_ov", overrun, m_ov);
      if ($urandom_range(1) == 1) begin
        read_pulse();
        m_valid = 1'b0;
        m_ov    = 1'b0;
        chk1("rnd_rd_dv", data_valid, m_valid);
        chk1("rnd_rd_ov", overrun, m_ov);
        if ($urandom_range(1) == 1) begin
          read_pulse();
          chk1("rnd_idle_rd_dv", data_valid, 1'b0);
        end
      end
    end

    // Read strobe on the exact commit cycle: new byte wins, no overrun
    read_pulse();
    send_frame(8'h5A, 1'b1, 1'b1, -1);
    chk1("simul_pre_dv", data_valid, 1'b1);
    send_frame(8'h96, 1'b1, 1'b1, COMMIT_IDX);
    chk8("simul_data", data, 8'h96);
    chk1("simul_dv", data_valid, 1'b1);
    chk1("simul_ov", overrun, 1'b0);

    // Mid-frame reset with a pending, overrun byte
    send_frame(8'h12, 1'b1, 1'b1, -1);
    chk1("pre_rst_ov", overrun, 1'b1);
    rx = 1'b0;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (4 * CPB) tick();
    chk1("pre_rst_busy", busy, 1'b1);
    reset = 1'b0;
    repeat (2) tick();
    chk8("mid_rst_data", data, 8'h00);
    chk1("mid_rst_dv", data_valid, 1'b0);
    chk1("mid_rst_pe", parity_error, 1'b0);
    chk1("mid_rst_fe", frame_error, 1'b0);
    chk1("mid_rst_ov", overrun, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    reset = 1'b1;
    repeat (CPB) tick();
    chk1("post_rst_dv", data_valid, 1'b0);
    send_frame(8'h55, 1'b1, 1'b1, -1);
    chk8("post_rst_data", data, 8'h55);
    chk1("post_rst_dv2", data_valid, 1'b1);
    chk1("post_rst_pe", parity_error, 1'b0);
    chk1("post_rst_fe", frame_error, 1'b0);
    chk1("post_rst_ov", overrun, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
